// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle ops, radix-2 Booth MUL, non-restoring signed DIV
// Results are held in ResultHi/ResultLo until the next result-writing edge.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       Op,
  input  logic             Branch,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] ResultHi,
  output logic [WIDTH-1:0] ResultLo
);

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_ADD  = 5'b00011, OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101, OP_OR   = 5'b00110, OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000, OP_SHR  = 5'b01001, OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110, OP_DIV  = 5'b01111, OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_BR   = 5'b10011;
  localparam logic [4:0] OP_SHLA = 5'b11111;

  typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, DIV_FIX} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   mul_a;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   a_sum;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH+1:0] div_p;
  logic [WIDTH+1:0] p_sh;
  logic [WIDTH+1:0] p_next;
  logic [WIDTH-1:0] fix_rem;
  logic [WIDTH-1:0] alu_lo;
  logic [WIDTH-1:0] ror_v;
  logic [WIDTH-1:0] rol_v;
  logic             qm1;
  logic             sign_q;
  logic             sign_r;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign sh = RB[SHW-1:0];

  // Bit indices wrap modulo WIDTH because they are SHW bits wide.
  always_comb begin
    ror_v = '0;
    rol_v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ror_v[i] = RA[SHW'(i) + sh];
      rol_v[i] = RA[SHW'(i) - sh];
    end
  end

  always_comb begin
    alu_lo = '0;
    case (Op)
      OP_LOAD, OP_ADD, OP_ADDI: alu_lo = RA + RB;
      OP_SUB:                   alu_lo = RA - RB;
      OP_AND, OP_ANDI:          alu_lo = RA & RB;
      OP_OR, OP_ORI:            alu_lo = RA | RB;
      OP_ROR:                   alu_lo = ror_v;
      OP_ROL:                   alu_lo = rol_v;
      OP_SHR:                   alu_lo = RA >> sh;
      OP_SHRA:                  alu_lo = $signed(RA) >>> sh;
      OP_SHL, OP_SHLA:          alu_lo = RA << sh;
      OP_NEG:                   alu_lo = -RB;
      OP_NOT:                   alu_lo = ~RB;
      OP_BR:                    alu_lo = Branch ? RA + RB : RA;
      default:                  alu_lo = '0;
    endcase
  end

  // Accumulator is one bit wider so A-M cannot overflow when M is the most negative value.
  always_comb begin
    case ({work_q[0], qm1})
      2'b01:   a_sum = mul_a + mcand;
      2'b10:   a_sum = mul_a - mcand;
      default: a_sum = mul_a;
    endcase
  end

  assign p_sh    = {div_p[WIDTH:0], work_q[WIDTH-1]};
  assign p_next  = div_p[WIDTH+1] ? p_sh + {2'b00, div_d} : p_sh - {2'b00, div_d};
  assign fix_rem = div_p[WIDTH+1] ? div_p[WIDTH-1:0] + div_d : div_p[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      ResultHi <= '0;
      ResultLo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            if (Op == OP_MUL) begin
              mul_a  <= '0;
              mcand  <= {RB[WIDTH-1], RB};
              work_q <= RA;
              qm1    <= 1'b0;
              cnt    <= SHW'(WIDTH - 1);
              busy   <= 1'b1;
              state  <= MUL_IT;
            end else if (Op == OP_DIV && RB == '0) begin
              ResultLo <= '1;
              ResultHi <= RA;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else if (Op == OP_DIV) begin
              div_p  <= '0;
              work_q <= mag(RA);
              div_d  <= mag(RB);
              sign_q <= RA[WIDTH-1] ^ RB[WIDTH-1];
              sign_r <= RA[WIDTH-1];
              cnt    <= SHW'(WIDTH - 1);
              busy   <= 1'b1;
              state  <= DIV_IT;
            end else begin
              ResultLo <= alu_lo;
              ResultHi <= '0;
              done     <= 1'b1;
            end
          end
        end
        MUL_IT: begin
          mul_a  <= {a_sum[WIDTH], a_sum[WIDTH:1]};
          work_q <= {a_sum[0], work_q[WIDTH-1:1]};
          qm1    <= work_q[0];
          if (cnt == '0) begin
            ResultHi <= a_sum[WIDTH:1];
            ResultLo <= {a_sum[0], work_q[WIDTH-1:1]};
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
        DIV_IT: begin
          div_p  <= p_next;
          work_q <= {work_q[WIDTH-2:0], ~p_next[WIDTH+1]};
          if (cnt == '0) state <= DIV_FIX;
          else           cnt   <= cnt - SHW'(1);
        end
        DIV_FIX: begin
          ResultLo <= sign_q ? -work_q : work_q;
          ResultHi <= sign_r ? -fix_rem : fix_rem;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=16
module tb_seq_alu;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  logic        s32, br32, busy32, done32, dz32;
  logic [4:0]  op32;
  logic [31:0] ra32, rb32, hi32, lo32;

  logic        s16, br16, busy16, done16, dz16;
  logic [4:0]  op16;
  logic [15:0] ra16, rb16, hi16, lo16;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) u32 (
    .clock(clock), .clear(clear), .start(s32), .Op(op32), .Branch(br32),
    .RA(ra32), .RB(rb32), .busy(busy32), .done(done32), .div_zero(dz32),
    .ResultHi(hi32), .ResultLo(lo32)
  );

  seq_alu #(.WIDTH(16)) u16 (
    .clock(clock), .clear(clear), .start(s16), .Op(op16), .Branch(br16),
    .RA(ra16), .RB(rb16), .busy(busy16), .done(done16), .div_zero(dz16),
    .ResultHi(hi16), .ResultLo(lo16)
  );

  task automatic issue32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
    @(negedge clock);
    s32 = 1'b1; op32 = op; ra32 = a; rb32 = b; br32 = 1'b0;
    @(negedge clock);
    s32 = 1'b0; ra32 = 32'hDEAD_BEEF; rb32 = 32'h1234_5678; op32 = 5'b00011;
    lat = 1; busy_cnt = 0;
    while (!done32 && lat < 100) begin
      if (busy32) busy_cnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic issue16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic br, output int lat);
    @(negedge clock);
    s16 = 1'b1; op16 = op; ra16 = a; rb16 = b; br16 = br;
    @(negedge clock);
    s16 = 1'b0; ra16 = 16'hBEEF; rb16 = 16'h0007; br16 = ~br;
    lat = 1;
    while (!done16 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy32); end
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done32); end
    checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b exp 0", dz32); end
    checks++; if ({hi32, lo32} !== 64'h0) begin errors++; $display("FAIL reset_result: got %h exp 0", {hi32, lo32}); end
    checks++; if ({busy16, done16, hi16, lo16} !== 34'h0) begin errors++; $display("FAIL reset_w16: got %h exp 0", {busy16, done16, hi16, lo16}); end
  endtask

  task automatic test_add();
    int lat, bc;
    issue32(5'b00011, 32'd5, 32'd7, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d exp 1", lat); end
    checks++; if (lo32 !== 32'h0000_000C) begin errors++; $display("FAIL add_lo: got %h exp 0000000c", lo32); end
    checks++; if (hi32 !== 32'h0) begin errors++; $display("FAIL add_hi: got %h exp 0", hi32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL add_busy: got %b exp 0", busy32); end
  endtask

  task automatic test_mul();
    int lat, bc;
    issue32(5'b10000, 32'hFFFF_FFFD, 32'd7, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d exp 33", lat); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d exp 32", bc); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done: got %b exp 0", busy32); end
    checks++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_neg3x7: got %h exp ffffffffffffffeb", {hi32, lo32}); end
    @(negedge clock);
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b exp 0", done32); end
    checks++; if (lo32 !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_held: got %h exp ffffffeb", lo32); end
    issue32(5'b10000, 32'h8000_0000, 32'h8000_0000, lat, bc);
    checks++; if ({hi32, lo32} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mul_minxmin: got %h exp 4000000000000000", {hi32, lo32}); end
    issue32(5'b10000, 32'd12345, 32'hFFFF_FFFF, lat, bc);
    checks++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_CFC7) begin errors++; $display("FAIL mul_x_neg1: got %h exp ffffffffffffcfc7", {hi32, lo32}); end
  endtask

  task automatic test_div();
    int lat, bc;
    issue32(5'b01111, 32'hFFFF_FFEF, 32'd5, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d exp 34", lat); end
    checks++; if (lo32 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot: got %h exp fffffffd", lo32); end
    checks++; if (hi32 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_rem: got %h exp fffffffe", hi32); end
    checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL div_dz_clear: got %b exp 0", dz32); end
    issue32(5'b01111, 32'd100, 32'hFFFF_FFF9, lat, bc);
    checks++; if ({hi32, lo32} !== 64'h0000_0002_FFFF_FFF2) begin errors++; $display("FAIL div_100_neg7: got %h exp 00000002fffffff2", {hi32, lo32}); end
    issue32(5'b01111, 32'd9, 32'd0, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d exp 1", lat); end
    checks++; if (dz32 !== 1'b1) begin errors++; $display("FAIL div0_flag: got %b exp 1", dz32); end
    checks++; if ({hi32, lo32} !== 64'h0000_0009_FFFF_FFFF) begin errors++; $display("FAIL div0_result: got %h exp 00000009ffffffff", {hi32, lo32}); end
  endtask

  task automatic test_abort();
    int seen_done = 0;
    @(negedge clock);
    s32 = 1'b1; op32 = 5'b10000; ra32 = 32'd3; rb32 = 32'd4;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      s32 = 1'b0;
      if (done32) seen_done++;
      if (k == 5) begin s32 = 1'b1; op32 = 5'b00011; ra32 = 32'd1; rb32 = 32'd1; end
      if (k == 10) begin
        checks++; if (lo32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL abort_held: got %h exp ffffffff", lo32); end
        clear = 1'b1;
      end
      if (k == 11) clear = 1'b0;
    end
    checks++; if ({busy32, done32, dz32, hi32, lo32} !== 67'h0) begin errors++; $display("FAIL abort_outputs: got %h exp 0", {busy32, done32, dz32, hi32, lo32}); end
    repeat (30) begin
      @(negedge clock);
      if (done32) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d exp 0", seen_done); end
    begin
      int lat, bc;
      issue32(5'b00011, 32'd1, 32'd1, lat, bc);
      checks++; if (lo32 !== 32'd2) begin errors++; $display("FAIL abort_then_add: got %h exp 2", lo32); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [3] = '{5'b00101, 5'b00110, 5'b00100};
    logic [31:0] as  [3] = '{32'hF0F0_F0F0, 32'h1234_0000, 32'd5};
    logic [31:0] bs  [3] = '{32'h0FF0_0FF0, 32'h0000_5678, 32'd7};
    logic [31:0] exp_lo [3] = '{32'h00F0_00F0, 32'h1234_5678, 32'hFFFF_FFFE};
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      s32 = 1'b1; op32 = ops[i]; ra32 = as[i]; rb32 = bs[i];
      @(negedge clock);
      checks++; if (done32 !== 1'b1 || lo32 !== exp_lo[i]) begin errors++; $display("FAIL b2b_%0d: got done=%b lo=%h exp done=1 lo=%h", i, done32, lo32, exp_lo[i]); end
    end
    s32 = 1'b0;
  endtask

  task automatic test_clear_start();
    @(negedge clock);
    clear = 1'b1; s32 = 1'b1; op32 = 5'b00011; ra32 = 32'd3; rb32 = 32'd4;
    @(negedge clock);
    clear = 1'b0; s32 = 1'b0;
    @(negedge clock);
    checks++; if (done32 !== 1'b0 || lo32 !== 32'h0) begin errors++; $display("FAIL clear_wins: got done=%b lo=%h exp done=0 lo=0", done32, lo32); end
  endtask

  task automatic test_w16();
    logic [4:0]  ops [9] = '{5'b00111, 5'b01010, 5'b10011, 5'b10011, 5'b01000,
                             5'b10001, 5'b10010, 5'b01001, 5'b11000};
    logic [15:0] as  [9] = '{16'h8001, 16'h8000, 16'h0100, 16'h0100, 16'h8001,
                             16'h0000, 16'h0000, 16'h8000, 16'h1234};
    logic [15:0] bs  [9] = '{16'h0001, 16'h0013, 16'h0010, 16'h0010, 16'h0004,
                             16'h0001, 16'h00FF, 16'h000F, 16'h5678};
    logic        brs [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] exp_lo [9] = '{16'hC000, 16'hF000, 16'h0110, 16'h0100, 16'h0018,
                                16'hFFFF, 16'hFF00, 16'h0001, 16'h0000};
    int lat;
    for (int i = 0; i < 9; i++) begin
      issue16(ops[i], as[i], bs[i], brs[i], lat);
      checks++; if (lat !== 1 || lo16 !== exp_lo[i] || hi16 !== 16'h0) begin errors++; $display("FAIL w16_op%0d: got lat=%0d hi=%h lo=%h exp lat=1 hi=0 lo=%h", i, lat, hi16, lo16, exp_lo[i]); end
    end
    issue16(5'b10000, 16'hFFFD, 16'h0007, 1'b0, lat);
    checks++; if (lat !== 17 || {hi16, lo16} !== 32'hFFFF_FFEB) begin errors++; $display("FAIL w16_mul: got lat=%0d %h exp lat=17 ffffffeb", lat, {hi16, lo16}); end
    issue16(5'b01111, 16'hFFEF, 16'h0005, 1'b0, lat);
    checks++; if (lat !== 18 || {hi16, lo16} !== 32'hFFFE_FFFD) begin errors++; $display("FAIL w16_div: got lat=%0d %h exp lat=18 fffefffd", lat, {hi16, lo16}); end
  endtask

  initial begin
    clear = 1'b1;
    s32 = 1'b0; op32 = '0; br32 = 1'b0; ra32 = '0; rb32 = '0;
    s16 = 1'b0; op16 = '0; br16 = 1'b0; ra16 = '0; rb16 = '0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_abort();
    test_back_to_back();
    test_clear_start();
    test_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
